// File: rtl/debug_loader.sv
// debug_loader: parses a framed program image from a byte stream and writes it
// word by word into the core's instruction memory through the debug port.
// Frame: MAGIC, 16-bit LE word count N, N little-endian 32-bit words and,
// when DEBUG_LOADER_CHECKSUM_EN is defined, a trailing mod-256 byte checksum.
// Optional feature macro: DEBUG_LOADER_CHECKSUM_EN (undefined by default).
module debug_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        DEBUG_SIG,
    output logic [31:0] DEBUG_addr,
    output logic [31:0] DEBUG_instr,
    output logic        clk_debug,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned LEN_X_W = LEN_W + 1;
    localparam int unsigned ADDR_W  = 32;
    localparam logic [LEN_X_W-1:0] MAX_N = LEN_X_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WSETUP,
        S_WSTROBE,
        S_CHK,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [LEN_W-1:0]    words_left_q, words_left_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic                rx_ready_q, rx_ready_d;
    logic                dbg_sig_q, dbg_sig_d;
    logic [ADDR_W-1:0]   dbg_addr_q, dbg_addr_d;
    logic [31:0]         dbg_instr_q, dbg_instr_d;
    logic                clk_debug_q, clk_debug_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic                xfer;
    logic [LEN_W-1:0]    len_full;

    // Byte transfer happens only when the registered ready is presented.
    assign xfer     = rx_valid && rx_ready_q;
    assign len_full = {rx_data, len_lo_q};

    // States in which a byte may be taken from the link.
    function automatic logic accepts(input state_t s);
        return (s == S_IDLE) || (s == S_LEN0) || (s == S_LEN1) ||
               (s == S_DATA) || (s == S_CHK);
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        addr_cnt_d   = addr_cnt_q;
        dbg_sig_d    = dbg_sig_q;
        dbg_addr_d   = dbg_addr_q;
        dbg_instr_d  = dbg_instr_q;
        clk_debug_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
`ifdef DEBUG_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (xfer && (rx_data == MAGIC)) begin
                    state_d    = S_LEN0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    dbg_sig_d  = 1'b1;
                    addr_cnt_d = BASE_ADDR;
                    byte_idx_d = 2'd0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end
            end

            S_LEN0: begin
                if (xfer) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end

            S_LEN1: begin
                if (xfer) begin
                    words_left_d = len_full;
                    if ({1'b0, len_full} > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (len_full == LEN_W'(0)) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef DEBUG_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WSETUP;
                    end
                end
            end

            // Present address/data a full cycle ahead of the strobe.
            S_WSETUP: begin
                dbg_addr_d  = addr_cnt_q;
                dbg_instr_d = word_q;
                state_d     = S_WSTROBE;
            end

            S_WSTROBE: begin
                clk_debug_d  = 1'b1;
                addr_cnt_d   = addr_cnt_q + ADDR_W'(4);
                words_left_d = words_left_q - LEN_W'(1);
                if (words_left_q == LEN_W'(1)) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end

`ifdef DEBUG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    if (rx_data != sum_q) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                    state_d = S_FIN;
                end
            end
`endif

            S_FIN: begin
                dbg_sig_d = 1'b0;
                busy_d    = 1'b0;
                if (!err_q) begin
                    done_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d = accepts(state_d);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'd0;
            words_left_q <= '0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
            addr_cnt_q   <= BASE_ADDR;
            rx_ready_q   <= 1'b0;
            dbg_sig_q    <= 1'b0;
            dbg_addr_q   <= '0;
            dbg_instr_q  <= 32'd0;
            clk_debug_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            addr_cnt_q   <= addr_cnt_d;
            rx_ready_q   <= rx_ready_d;
            dbg_sig_q    <= dbg_sig_d;
            dbg_addr_q   <= dbg_addr_d;
            dbg_instr_q  <= dbg_instr_d;
            clk_debug_q  <= clk_debug_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign rx_ready    = rx_ready_q;
    assign DEBUG_SIG   = dbg_sig_q;
    assign DEBUG_addr  = dbg_addr_q;
    assign DEBUG_instr = dbg_instr_q;
    assign clk_debug   = clk_debug_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
